// File: rtl/aes_block_serializer.sv
// Transmit side of the block link: captures a parallel AES block and streams it out
// MS word first over a valid/ready handshake, pulsing done after the last word.
module aes_block_serializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_WORDS  = 16,
  parameter int unsigned CNT_BITS   = 5
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             load,
  input  logic [DATA_WIDTH*NUM_WORDS-1:0]  block_in,
  input  logic                             abort,
  input  logic                             tx_ready,
  output logic                             tx_valid,
  output logic [DATA_WIDTH-1:0]            tx_data,
  output logic                             busy,
  output logic [CNT_BITS-1:0]              word_count,
  output logic                             done
);

  localparam int unsigned BlockWidth = DATA_WIDTH * NUM_WORDS;
  localparam logic [CNT_BITS-1:0] LastIdx = CNT_BITS'(NUM_WORDS - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSend = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [BlockWidth-1:0] shreg_q, shreg_d;
  logic [CNT_BITS-1:0]   count_q, count_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  xfer;

  assign xfer = valid_q & tx_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (load) begin
          shreg_d = block_in;
          count_d = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        // abort takes priority over a transfer on the same edge
        if (abort) begin
          shreg_d = '0;
          count_d = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (xfer) begin
          count_d = count_q + 1'b1;
          if (count_q == LastIdx) begin
            shreg_d = '0;
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            shreg_d = shreg_q << DATA_WIDTH;
          end
        end
      end
      StDone: begin
        // done already pulsed on entry; abort here lands in the same place
        count_d = '0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        shreg_d = '0;
        count_d = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // The shift register top word is the registered output word; it is zero when idle.
  assign tx_data    = shreg_q[BlockWidth-1 -: DATA_WIDTH];
  assign tx_valid   = valid_q;
  assign busy       = busy_q;
  assign word_count = count_q;
  assign done       = done_q;

endmodule
